// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the RV32I fetch stage.
//   XLEN          datapath width
//   NOP_INSTR     bubble instruction (addi x0,x0,0)
//   fetch_state_t fetch FSM states
package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // request outstanding on the bus (imem_req high)
      WAIT = 2'd1,   // request accepted, waiting for the response
      KILL = 2'd2,   // accepted request went stale; swallow its response
      HOLD = 2'd3    // response captured during a stall, parked in hold_q
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Keeps the fetch PC, issues one
// instruction-memory request at a time and hands InstrF/PCF/PCPlus4F to IF/ID.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   StallF              hazard stall: hold PC, do not consume an instruction
//   PCSrcE, PCTargetE   redirect from Execute (wins over StallF)
//   imem_req/addr       request valid / address (address is always PCF)
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   response valid / instruction word
//   InstrF, FetchValidF instruction for IF/ID (NOP_INSTR when not valid)
//   PCF, PCPlus4F       PC of InstrF and PC + 4
//   InstrMisalignF      only with FETCH_ALIGN_CHECK_EN: last redirect target
//                       was not word aligned; fetching is suspended
//
// Build option: define FETCH_ALIGN_CHECK_EN to enable the misalignment trap.
// Without it the low two target bits are forced to zero on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            FetchValidF
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic            InstrMisalignF
`endif
);

   fetch_state_t    state, stateNext;
   logic [XLEN-1:0] pc_q, pcNext, hold_q, redirPc;
   logic            advance, capture, misalign;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q;

   assign redirPc        = PCTargetE;
   assign misalign       = misalign_q;
   assign InstrMisalignF = misalign_q;

   // Every redirect re-evaluates alignment, so a good target clears the trap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        misalign_q <= 1'b0;
      else if (PCSrcE) misalign_q <= |PCTargetE[1:0];
   end
`else
   logic unusedTgtLo;

   assign unusedTgtLo = ^PCTargetE[1:0];
   assign redirPc     = {PCTargetE[XLEN-1:2], 2'b00};
   assign misalign    = 1'b0;
`endif

   assign PCF       = pc_q;
   assign PCPlus4F  = pc_q + 32'd4;
   assign imem_addr = pc_q;

   always_comb begin
      stateNext   = state;
      advance     = 1'b0;
      capture     = 1'b0;
      imem_req    = 1'b0;
      InstrF      = NOP_INSTR;
      FetchValidF = 1'b0;
      case (state)
         IDLE: begin
            imem_req = rst & ~misalign;
            // A redirect does not withdraw the request; if it is accepted
            // anyway, its response belongs to the old path and must be killed.
            if (PCSrcE)                      stateNext = (imem_req && imem_ready) ? KILL : IDLE;
            else if (imem_req && imem_ready) stateNext = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               if (PCSrcE) begin
                  stateNext = IDLE;
               end else if (StallF) begin
                  capture   = 1'b1;
                  stateNext = HOLD;
               end else begin
                  InstrF      = imem_rdata;
                  FetchValidF = 1'b1;
                  advance     = 1'b1;
                  stateNext   = IDLE;
               end
            end else if (PCSrcE) begin
               stateNext = KILL;
            end
         end
         KILL: begin
            if (imem_rvalid) stateNext = IDLE;
         end
         HOLD: begin
            if (PCSrcE) begin
               stateNext = IDLE;
            end else if (!StallF) begin
               InstrF      = hold_q;
               FetchValidF = 1'b1;
               advance     = 1'b1;
               stateNext   = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Redirect outranks advance in every state.
   assign pcNext = PCSrcE  ? redirPc       :
                   advance ? pc_q + 32'd4  : pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pc_q   <= RESET_PC;
         hold_q <= '0;
      end else begin
         state <= stateNext;
         pc_q  <= pcNext;
         if (capture) hold_q <= imem_rdata;
      end
   end

endmodule
